// File: rtl/fifo_unpack.sv
// Width down-converting FIFO: stores 32-bit packed words with a last-nibble index
// and hands them back one nibble per pop, with a flush/drain handshake.
module fifo_unpack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_wr_valid_i,
  input  logic [31:0] fifo_wr_data_i,
  input  logic [2:0]  fifo_wr_nib_cnt_i,
  output logic        fifo_data_avail_o,
  input  logic        fifo_rd_valid_i,
  output logic [3:0]  fifo_rd_data_o,
  input  logic        fifo_flush_i,
  output logic        fifo_flush_done_o,
  output logic        fifo_empty_o,
  output logic        fifo_full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t      state;
  logic [31:0] mem_data [DEPTH];
  logic [2:0]  mem_cnt  [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [2:0]  nib_idx;

  logic [31:0] head_data;
  logic [2:0]  head_cnt;
  logic        wr_en;
  logic        rd_en;

  assign fifo_empty_o      = (wr_ptr == rd_ptr);
  assign fifo_full_o       = (wr_ptr[AW] != rd_ptr[AW]) &&
                             (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_data_avail_o = !fifo_empty_o;
  assign fifo_flush_done_o = (state == DONE);

  assign head_data = mem_data[rd_ptr[AW-1:0]];
  assign head_cnt  = mem_cnt[rd_ptr[AW-1:0]];

  // Flags come from registered pointers, so a pop never frees a slot for a same-cycle write.
  assign wr_en = fifo_wr_valid_i && !fifo_full_o && (state == IDLE);
  assign rd_en = fifo_rd_valid_i && !fifo_empty_o;

  always_comb begin
    fifo_rd_data_o = '0;
    if (!fifo_empty_o) begin
      fifo_rd_data_o = head_data[{nib_idx, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data <= '{default: '0};
      mem_cnt  <= '{default: '0};
      wr_ptr   <= '0;
    end else if (wr_en) begin
      mem_data[wr_ptr[AW-1:0]] <= fifo_wr_data_i;
      mem_cnt[wr_ptr[AW-1:0]]  <= fifo_wr_nib_cnt_i;
      wr_ptr                   <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      nib_idx <= '0;
    end else if (rd_en) begin
      if (nib_idx == head_cnt) begin
        rd_ptr  <= rd_ptr + 1'b1;
        nib_idx <= '0;
      end else begin
        nib_idx <= nib_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (fifo_flush_i) state <= DRAIN;
        DRAIN: begin
          if (!fifo_flush_i)     state <= IDLE;
          else if (fifo_empty_o) state <= DONE;
        end
        DONE:    if (!fifo_flush_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
